// File: rtl/axi_to_ahb_pkg.sv
// Shared definitions for the AXI-to-AHB bridge command path.
package axi_to_ahb_pkg;

    // Command FSM state encoding.
    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StIssue = 1'b1;

    // Request/grant vector positions used by the two-way arbiter.
    localparam int unsigned GntWrite = 0;
    localparam int unsigned GntRead  = 1;

    // Width of the outstanding-command counter.
    localparam int unsigned OutstandingWidth = 8;

    // The ID FIFO word is {is_write, id}; the flag sits just above the ID field.
    function automatic int unsigned is_write_bit(input int unsigned id_width);
        return id_width;
    endfunction

endpackage

// File: rtl/axi_cmd_arbiter_if.sv
// Bundle of AXI address channels, AHB command channel, ID FIFO push side and
// completion/outstanding signals around the command arbiter.
interface axi_cmd_arbiter_if #(
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 32
);
    // AXI write address channel
    logic                      awvalid;
    logic                      awready;
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;

    // AXI read address channel
    logic                      arvalid;
    logic                      arready;
    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;

    // Command channel to the AHB master engine
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]                cmd_len;

    // ID FIFO push side
    logic [AXI_ID_WIDTH:0]     idf_data;
    logic                      idf_write_en;
    logic                      idf_full;

    // Response-side completion and outstanding count
    logic                      cpl;
    logic [7:0]                outstanding;

    // Arbiter side
    modport slave (
        input  awvalid, awid, awaddr, awlen,
        input  arvalid, arid, araddr, arlen,
        input  cmd_ready, idf_full, cpl,
        output awready, arready,
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output idf_data, idf_write_en, outstanding
    );

    // Environment side
    modport master (
        output awvalid, awid, awaddr, awlen,
        output arvalid, arid, araddr, arlen,
        output cmd_ready, idf_full, cpl,
        input  awready, arready,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  idf_data, idf_write_en, outstanding
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. req[0] is write, req[1] is read. The grant is
// combinational; the last-grant flag only moves when advance is asserted.
module rr_arb2
    import axi_to_ahb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 = read was granted last, so write has priority on the next tie.
    logic last_read_q;
    logic last_read_d;

    // Pick a winner; on a tie favour the side that did not win last time.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant[GntWrite] = 1'b1;
            2'b10:   grant[GntRead]  = 1'b1;
            2'b11: begin
                if (last_read_q) begin
                    grant[GntWrite] = 1'b1;
                end else begin
                    grant[GntRead]  = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when the grant is actually consumed.
    always_comb begin
        last_read_d = last_read_q;
        if (advance) begin
            last_read_d = grant[GntRead];
        end
    end

    // Last-grant register; reset makes write the first tie winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_read_q <= 1'b1;
        end else begin
            last_read_q <= last_read_d;
        end
    end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Arbitrates AXI write/read address requests into a single AHB command
// stream, pushes {is_write, id} into the ID FIFO on every accept and tracks
// the number of commands in flight.
module axi_cmd_arbiter
    import axi_to_ahb_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH    = 8,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned MAX_OUTSTANDING = 128
) (
    input  logic               clk,
    input  logic               reset,
    axi_cmd_arbiter_if.slave   bus
);

    localparam int unsigned IS_WRITE_BIT = is_write_bit(AXI_ID_WIDTH);
    localparam int unsigned CntW         = OutstandingWidth + 1;
    localparam logic [CntW-1:0] MaxOut   = CntW'(MAX_OUTSTANDING);

    logic [0:0]                state_q, state_d;
    logic                      cmd_valid_q, cmd_valid_d;
    logic                      cmd_write_q, cmd_write_d;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]                cmd_len_q, cmd_len_d;
    logic [OutstandingWidth-1:0] outstanding_q, outstanding_d;

    logic              below_limit;
    logic              can_take;
    logic              slot_free;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic              win_write;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [AXI_ID_WIDTH:0] idf_word;

    // A request may only be taken when the ID FIFO has room, the in-flight cap
    // is not reached and we are not in reset.
    always_comb begin
        below_limit = {1'b0, outstanding_q} < MaxOut;
        can_take    = !reset && !bus.idf_full && below_limit;
        req         = 2'b00;
        req[GntWrite] = bus.awvalid && can_take;
        req[GntRead]  = bus.arvalid && can_take;
        // The command slot is free when idle or when the current command
        // is being handed off this cycle.
        slot_free   = (state_q == StIdle) || bus.cmd_ready;
        accept      = slot_free && (req != 2'b00);
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    assign win_write = grant[GntWrite];

    // Handshake strobes and ID FIFO word for the accept cycle.
    always_comb begin
        idf_word = '0;
        if (accept) begin
            idf_word[IS_WRITE_BIT]       = win_write;
            idf_word[AXI_ID_WIDTH-1:0]   = win_write ? bus.awid : bus.arid;
        end
    end

    assign bus.awready      = accept && grant[GntWrite];
    assign bus.arready      = accept && grant[GntRead];
    assign bus.idf_write_en = accept;
    assign bus.idf_data     = idf_word;

    // FSM next state and command register load.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        if (accept) begin
            state_d     = StIssue;
            cmd_valid_d = 1'b1;
            cmd_write_d = win_write;
            cmd_addr_d  = win_write ? bus.awaddr : bus.araddr;
            cmd_len_d   = win_write ? bus.awlen  : bus.arlen;
        end else if ((state_q == StIssue) && bus.cmd_ready) begin
            state_d     = StIdle;
            cmd_valid_d = 1'b0;
        end
    end

    // Outstanding count: accept and completion in one cycle cancel out, and
    // a completion with nothing outstanding is dropped so the count never wraps.
    always_comb begin
        cnt_inc       = accept;
        cnt_dec       = bus.cpl && (outstanding_q != '0);
        outstanding_d = outstanding_q;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers; reset drops any pending command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_write   = cmd_write_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Self-checking bench for axi_cmd_arbiter. Inputs change on the falling edge,
// combinational outputs are sampled 1 time unit later, and a scoreboard checks
// the latched command 1 time unit after each rising edge that follows a
// predicted accept.
module tb_axi_cmd_arbiter;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q[$];
    cmd_t last_cmd;
    cmd_t mon_e;

    axi_cmd_arbiter_if #(.AXI_ID_WIDTH(8), .AXI_ADDR_WIDTH(32)) bus ();

    axi_cmd_arbiter #(
        .AXI_ID_WIDTH    (8),
        .AXI_ADDR_WIDTH  (32),
        .MAX_OUTSTANDING (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every predicted accept must show up as the latched command.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e    = exp_q.pop_front();
            last_cmd = mon_e;
            checks++;
            if ({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_len} !== {1'b1, mon_e}) begin
                errors++;
                $display("FAIL sb_cmd got v=%b w=%b addr=%h len=%h want v=1 w=%b addr=%h len=%h",
                         bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_len,
                         mon_e.w, mon_e.addr, mon_e.len);
            end
        end
    end

    task automatic set_in(input logic aw, input logic ar, input logic rdy, input logic full,
                          input logic c);
        bus.awvalid   = aw;
        bus.arvalid   = ar;
        bus.cmd_ready = rdy;
        bus.idf_full  = full;
        bus.cpl       = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.awid = 8'h01; bus.awaddr = 32'h10; bus.awlen = 8'd1;
        bus.arid = 8'h02; bus.araddr = 32'h20; bus.arlen = 8'd2;
        set_in(1, 1, 1, 0, 1);
        #1;
        checks++;
        if ({bus.awready, bus.arready, bus.idf_write_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_readies got aw=%b ar=%b we=%b want 000",
                     bus.awready, bus.arready, bus.idf_write_en);
        end
        checks++;
        if (bus.idf_data !== 9'h000) begin
            errors++; $display("FAIL rst_idf_data got %h want 000", bus.idf_data);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.outstanding} !== '0) begin
            errors++;
            $display("FAIL rst_state got v=%b w=%b addr=%h len=%h out=%0d want all 0",
                     bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.outstanding);
        end
        checks++;
        if ({bus.awready, bus.arready, bus.idf_write_en} !== 3'b000) begin
            errors++; $display("FAIL rst_readies2 got %b want 000",
                               {bus.awready, bus.arready, bus.idf_write_en});
        end
        set_in(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.awid = 8'h12; bus.awaddr = 32'h1000; bus.awlen = 8'd3;
        set_in(1, 0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.awready, bus.arready, bus.idf_write_en} !== 3'b101) begin
            errors++; $display("FAIL sw_ready got %b want 101",
                               {bus.awready, bus.arready, bus.idf_write_en});
        end
        checks++;
        if (bus.idf_data !== 9'h112) begin
            errors++; $display("FAIL sw_idf_data got %h want 112", bus.idf_data);
        end
        exp_q.push_back('{w: 1'b1, addr: 32'h1000, len: 8'd3});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd1) begin
            errors++; $display("FAIL sw_out got %0d want 1", bus.outstanding);
        end
        @(negedge clk);
        set_in(0, 0, 1, 0, 0);
        #1;
        checks++;
        if ({bus.cmd_valid, bus.awready} !== 2'b10) begin
            errors++; $display("FAIL sw_hold got v=%b aw=%b want v=1 aw=0",
                               bus.cmd_valid, bus.awready);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 1);
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL sw_idle got v=%b want 0", bus.cmd_valid);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd0) begin
            errors++; $display("FAIL sw_cpl got %0d want 0", bus.outstanding);
        end
    endtask

    task automatic test_contention();
        logic want_w;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.awid = 8'(8'h20 + i); bus.awaddr = 32'(32'h2000 + i * 16); bus.awlen = 8'(i);
            bus.arid = 8'(8'h40 + i); bus.araddr = 32'(32'h3000 + i * 16); bus.arlen = 8'(8'h80 + i);
            set_in(1, 1, 1, 0, 0);
            #1;
            want_w = (i % 2 == 0);
            checks++;
            if ({bus.awready, bus.arready} !== {want_w, !want_w}) begin
                errors++; $display("FAIL rr_grant[%0d] got aw=%b ar=%b want aw=%b ar=%b",
                                   i, bus.awready, bus.arready, want_w, !want_w);
            end
            checks++;
            if (bus.idf_data !== (want_w ? {1'b1, bus.awid} : {1'b0, bus.arid})) begin
                errors++; $display("FAIL rr_idf[%0d] got %h want_write=%b", i, bus.idf_data, want_w);
            end
            checks++;
            if (bus.outstanding !== 8'(i)) begin
                errors++; $display("FAIL rr_out[%0d] got %0d want %0d", i, bus.outstanding, i);
            end
            if (i > 0) begin
                checks++;
                if (bus.cmd_valid !== 1'b1) begin
                    errors++; $display("FAIL rr_valid[%0d] got 0 want 1", i);
                end
            end
            exp_q.push_back('{w: want_w, addr: want_w ? bus.awaddr : bus.araddr,
                              len: want_w ? bus.awlen : bus.arlen});
        end
        @(negedge clk);
        set_in(0, 0, 1, 0, 0);
        #1;
        checks++;
        if ({bus.cmd_valid, bus.awready, bus.arready, bus.outstanding} !== {3'b100, 8'd6}) begin
            errors++; $display("FAIL rr_tail got v=%b aw=%b ar=%b out=%0d want v=1 out=6",
                               bus.cmd_valid, bus.awready, bus.arready, bus.outstanding);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL rr_drain got v=%b want 0", bus.cmd_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        bus.awid = 8'h31; bus.awaddr = 32'h5000; bus.awlen = 8'd7;
        bus.arid = 8'h32; bus.araddr = 32'h6000; bus.arlen = 8'd9;
        set_in(1, 1, 0, 0, 0);
        #1;
        checks++;
        if ({bus.awready, bus.arready} !== 2'b10) begin
            errors++; $display("FAIL bp_first got aw=%b ar=%b want 10", bus.awready, bus.arready);
        end
        exp_q.push_back('{w: 1'b1, addr: 32'h5000, len: 8'd7});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.awaddr = 32'(32'h5004 + k);
            set_in(1, 1, 0, 0, 0);
            #1;
            checks++;
            if ({bus.awready, bus.arready, bus.idf_write_en} !== 3'b000) begin
                errors++; $display("FAIL bp_stall_ready[%0d] got %b want 000", k,
                                   {bus.awready, bus.arready, bus.idf_write_en});
            end
            checks++;
            if ({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_len} !== {1'b1, last_cmd}) begin
                errors++; $display("FAIL bp_stable[%0d] got w=%b addr=%h len=%h want addr=5000",
                                   k, bus.cmd_write, bus.cmd_addr, bus.cmd_len);
            end
        end
        @(negedge clk);
        set_in(1, 1, 1, 0, 0);
        #1;
        checks++;
        if ({bus.awready, bus.arready, bus.idf_data} !== {2'b01, 9'h032}) begin
            errors++; $display("FAIL bp_release got aw=%b ar=%b idf=%h want ar=1 idf=032",
                               bus.awready, bus.arready, bus.idf_data);
        end
        exp_q.push_back('{w: 1'b0, addr: 32'h6000, len: 8'd9});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd2) begin
            errors++; $display("FAIL bp_out got %0d want 2", bus.outstanding);
        end
        @(negedge clk);
        set_in(0, 0, 1, 0, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle got v=%b want 0", bus.cmd_valid);
        end
    endtask

    task automatic test_limit();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            bus.awid = 8'(i); bus.awaddr = 32'(32'h4000 + i * 4); bus.awlen = 8'(i);
            set_in(1, 0, 1, 0, 0);
            #1;
            checks++;
            if (bus.awready !== 1'b1) begin
                errors++; $display("FAIL lim_accept[%0d] got 0 want 1", i);
            end
            exp_q.push_back('{w: 1'b1, addr: bus.awaddr, len: bus.awlen});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_in(1, 0, 1, 0, 0);
            #1;
            checks++;
            if ({bus.awready, bus.idf_write_en, bus.outstanding} !== {2'b00, 8'd128}) begin
                errors++; $display("FAIL lim_full[%0d] got aw=%b we=%b out=%0d want 0 0 128",
                                   k, bus.awready, bus.idf_write_en, bus.outstanding);
            end
        end
        @(negedge clk);
        set_in(1, 0, 1, 0, 1);
        #1;
        checks++;
        if (bus.awready !== 1'b0) begin
            errors++; $display("FAIL lim_cpl_cycle got aw=1 want 0");
        end
        @(negedge clk);
        bus.awid = 8'h99; bus.awaddr = 32'h9000; bus.awlen = 8'd5;
        set_in(1, 0, 1, 0, 0);
        #1;
        checks++;
        if ({bus.awready, bus.outstanding} !== {1'b1, 8'd127}) begin
            errors++; $display("FAIL lim_reopen got aw=%b out=%0d want aw=1 out=127",
                               bus.awready, bus.outstanding);
        end
        exp_q.push_back('{w: 1'b1, addr: 32'h9000, len: 8'd5});
        @(negedge clk);
        set_in(0, 0, 1, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd128) begin
            errors++; $display("FAIL lim_refill got %0d want 128", bus.outstanding);
        end
    endtask

    task automatic test_idf_full();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.arid = 8'h50; bus.araddr = 32'h7000; bus.arlen = 8'd1;
            set_in(0, 1, 1, 1, 0);
            #1;
            checks++;
            if ({bus.arready, bus.idf_write_en} !== 2'b00) begin
                errors++; $display("FAIL full_block[%0d] got ar=%b we=%b want 00",
                                   k, bus.arready, bus.idf_write_en);
            end
        end
        @(negedge clk);
        bus.arid = 8'h55; bus.araddr = 32'h7000; bus.arlen = 8'd1;
        set_in(0, 1, 0, 0, 0);
        #1;
        checks++;
        if ({bus.arready, bus.idf_data} !== {1'b1, 9'h055}) begin
            errors++; $display("FAIL full_release got ar=%b idf=%h want 1 055",
                               bus.arready, bus.idf_data);
        end
        exp_q.push_back('{w: 1'b0, addr: 32'h7000, len: 8'd1});
        @(negedge clk);
        bus.arid = 8'h56; bus.araddr = 32'h7100; bus.arlen = 8'd2;
        set_in(0, 1, 1, 0, 1);
        #1;
        checks++;
        if ({bus.arready, bus.outstanding} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL full_b2b got ar=%b out=%0d want 1 1",
                               bus.arready, bus.outstanding);
        end
        exp_q.push_back('{w: 1'b0, addr: 32'h7100, len: 8'd2});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd1) begin
            errors++; $display("FAIL acc_cpl_same got %0d want 1", bus.outstanding);
        end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        @(negedge clk);
        bus.awid = 8'h77; bus.awaddr = 32'h8000; bus.awlen = 8'd4;
        set_in(1, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.awready !== 1'b1) begin
            errors++; $display("FAIL ri_accept got 0 want 1");
        end
        exp_q.push_back('{w: 1'b1, addr: 32'h8000, len: 8'd4});
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd1) begin
            errors++; $display("FAIL ri_out got %0d want 1", bus.outstanding);
        end
        @(negedge clk);
        reset = 1'b1;
        set_in(1, 1, 1, 0, 0);
        #1;
        checks++;
        if ({bus.awready, bus.arready, bus.idf_write_en, bus.idf_data} !== 12'h000) begin
            errors++; $display("FAIL ri_gate got aw=%b ar=%b we=%b idf=%h want 0",
                               bus.awready, bus.arready, bus.idf_write_en, bus.idf_data);
        end
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.cmd_valid, bus.outstanding} !== 9'h000) begin
            errors++; $display("FAIL ri_drop got v=%b out=%0d want 0 0",
                               bus.cmd_valid, bus.outstanding);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.outstanding !== 8'd0) begin
            errors++; $display("FAIL cpl_at_zero got %0d want 0", bus.outstanding);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_limit();
        test_idf_full();
        test_reset_in_issue();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_cmd_arbiter.md
AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 8, AXI ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 128, cap on commands issued but not completed; must be ≤ ID FIFO depth.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- awvalid/awready  in/out  1/1  AXI write address handshake.
- awid, awaddr, awlen  in  AXI_ID_WIDTH, AXI_ADDR_WIDTH, 8  write command fields.
- arvalid/arready  in/out  1/1  AXI read address handshake.
- arid, araddr, arlen  in  AXI_ID_WIDTH, AXI_ADDR_WIDTH, 8  read command fields.
- cmd_valid/cmd_ready  out/in  1/1  command handshake to the AHB master engine.
- cmd_write, cmd_addr, cmd_len  out  1, AXI_ADDR_WIDTH, 8  granted command; cmd_write=1 means write.
- idf_data  out  AXI_ID_WIDTH+1  ID FIFO push word {cmd_write, id}.
- idf_write_en  out  1  ID FIFO push strobe.
- idf_full  in  1  ID FIFO full.
- cpl  in  1  one-cycle pulse, one command completed on the response side.
- outstanding  out  8  current outstanding count.

Function
REQ-005 SHALL use FSM states IDLE and ISSUE.
REQ-006 Eligibility: a request is eligible when its valid=1, idf_full=0 and outstanding < MAX_OUTSTANDING.
REQ-007 Accept cycle: the FSM is in IDLE, or in ISSUE with cmd_ready=1, and at least one request is eligible.
REQ-008 In an accept cycle, the winner's ready SHALL be 1 for exactly that cycle; the loser's ready SHALL be 0.
REQ-009 In an accept cycle, idf_write_en=1 and idf_data={is_write, winner id}, both combinational in the same cycle.
REQ-010 On the next edge after an accept cycle: latch cmd_write/addr/len, set cmd_valid=1, enter ISSUE.
REQ-011 Arbitration: single eligible request wins; if both are eligible, the one not granted last wins (round-robin).
REQ-012 The last-grant flag SHALL update only in an accept cycle; its reset value selects write first.
REQ-013 In ISSUE, cmd_* SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-014 ISSUE with cmd_ready=1 and no eligible request SHALL return to IDLE with cmd_valid=0.
REQ-015 ISSUE with cmd_ready=1 and an eligible request SHALL accept it back-to-back; cmd_valid stays 1 with the new fields.
REQ-016 No ready or idf_write_en SHALL assert while idf_full=1 or outstanding = MAX_OUTSTANDING.
REQ-017 outstanding update: +1 on accept, -1 on cpl, unchanged when both occur in the same cycle.
REQ-018 cpl with outstanding=0 SHALL be ignored; outstanding never wraps.
REQ-019 awready and arready SHALL never both be 1 in the same cycle.

Reset
REQ-020 reset=1 SHALL force IDLE, cmd_valid=0, cmd_write/addr/len=0, outstanding=0, last-grant=read.
REQ-021 While reset=1, awready, arready and idf_write_en SHALL be 0, and idf_data SHALL be 0.
REQ-022 Reset asserted mid-ISSUE SHALL drop the pending command with no handshake completed; the upstream FIFO is reset on the same event.

Structure
REQ-023 FSM state encoding and the FIFO word bit index (IS_WRITE_BIT=AXI_ID_WIDTH) SHALL live in shared package axi_to_ahb_pkg.
REQ-024 The round-robin two-way arbiter SHALL be sub-module rr_arb2 (req[1:0], advance, grant[1:0]).

Verification
REQ-025 Single write: awvalid=1, awid=0x12, awaddr=0x1000, awlen=3 in IDLE -> awready=1 and idf_data=0x112 that cycle; next cycle cmd_valid=1, cmd_write=1, cmd_addr=0x1000, cmd_len=3.
REQ-026 Contention: awvalid=arvalid=1 continuously, cmd_ready=1 -> grants alternate W,R,W,R after reset; cmd_valid stays 1 throughout.
REQ-027 Backpressure: cmd_ready=0 for 5 cycles -> cmd_* stable, no further readies; first cycle with cmd_ready=1 accepts the next request.
REQ-028 Limit: 128 accepts with no cpl -> outstanding=128 and readies stay 0; one cpl pulse -> outstanding=127, next request accepted.
REQ-029 idf_full=1 with arvalid=1 -> arready=0 and idf_write_en=0; simultaneous accept and cpl -> outstanding unchanged.
REQ-030 Reset asserted in ISSUE -> next cycle cmd_valid=0 and outstanding=0; cpl with outstanding=0 -> count stays 0.
